// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared types and constants for the quad-SPI memory controller
package qspi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    DONE
  } state_t;

  localparam logic [7:0] DEF_RD_CMD = 8'hEB;
  localparam logic [7:0] DEF_WR_CMD = 8'h38;

  localparam logic [3:0] OEN_IDLE  = 4'b0000;
  localparam logic [3:0] OEN_CMD   = 4'b0001;
  localparam logic [3:0] OEN_ADDR  = 4'b1111;
  localparam logic [3:0] OEN_DUMMY = 4'b0000;
  localparam logic [3:0] OEN_WDATA = 4'b1111;
  localparam logic [3:0] OEN_RDATA = 4'b0000;

  // Bit offset of data nibble idx in the 32-bit word: bytes ascend, high nibble first
  function automatic logic [4:0] nib_off(input logic [2:0] idx);
    return {idx[2:1], ~idx[0], 2'b00};
  endfunction

endpackage

// File: rtl/qspi_sck_gen.sv
// rtl/qspi_sck_gen.sv - SCK divider with rise/fall strobes for the phase FSM
module qspi_sck_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt;
  logic          edge_due;

  // Strobes flag the clk edge that is about to move SCK, so the FSM acts on that same edge
  assign edge_due = run_i && (cnt == LAST);
  assign rise_o   = edge_due && !sck_o;
  assign fall_o   = edge_due && sck_o;

  // Half-period counter; SCK parks low whenever the bus is not running
  always_ff @(posedge clk_i) begin
    if (rst_i || !run_i) begin
      cnt   <= '0;
      sck_o <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      sck_o <= ~sck_o;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/qspi_mem_ctrl.sv
// rtl/qspi_mem_ctrl.sv - quad-SPI memory controller for NUM_CS devices on a shared bus
module qspi_mem_ctrl
  import qspi_pkg::*;
#(
  parameter int          NUM_CS    = 2,
  parameter int          ADDR_W    = 24,
  parameter int          DUMMY_CYC = 4,
  parameter int          CLK_DIV   = 1,
  parameter logic [7:0]  RD_CMD    = DEF_RD_CMD,
  parameter logic [7:0]  WR_CMD    = DEF_WR_CMD,
  localparam int         CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [CS_W-1:0]   cs_sel_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        size_i,
  input  logic [31:0]       wdata_i,
  output logic              ack_o,
  output logic [31:0]       rdata_o,
  output logic              busy_o,
  output logic [NUM_CS-1:0] mem_cs_on,
  output logic              mem_sck_o,
  input  logic [3:0]        mem_sd_i,
  output logic [3:0]        mem_sd_o,
  output logic [3:0]        mem_sd_oen_o
);

  localparam int ANIB   = ADDR_W / 4;
  localparam int MAX_PH = (DUMMY_CYC > 8) ? DUMMY_CYC : 8;
  localparam int CNT_W  = $clog2(MAX_PH);
  localparam int GAP_W  = $clog2(2 * CLK_DIV);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_m1;
  logic [GAP_W-1:0]    gap;
  logic                op_we;
  logic                op_sel_ok;
  logic [7:0]          op_cmd;
  logic [ADDR_W-1:0]   op_addr;
  logic [1:0]          op_size;
  logic [31:0]         op_wdata;
  logic [31:0]         rd_buf;
  logic [NUM_CS-1:0]   cs_mask;
  logic                run;
  logic                sck_rise;
  logic                sck_fall;
  logic [2:0]          last_idx;
  logic [2:0]          data_idx;
  logic [4:0]          data_off;
  logic [3:0]          shift_nib;
  logic [7:0]          cmd_sh;
  logic [ADDR_W-1:0]   addr_sh;
  logic [31:0]         wdata_sh;

  assign run      = (state == CMD) || (state == ADDR) || (state == DUMMY) || (state == DATA);
  assign cnt_m1   = cnt - 1'b1;
  assign last_idx = {op_size, 1'b1};
  assign data_idx = last_idx - cnt[2:0];
  assign data_off = nib_off(data_idx);

  qspi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .run_i  (run),
    .sck_o  (mem_sck_o),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  // Active-low select pattern for the requested device; all high when the index is out of range
  always_comb begin
    cs_mask = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (CS_W'(i) == cs_sel_i) cs_mask[i] = 1'b0;
    end
  end

  // Next nibble to present when a phase continues past an SCK fall
  always_comb begin
    shift_nib = 4'h0;
    cmd_sh    = op_cmd >> cnt_m1;
    addr_sh   = op_addr >> {cnt_m1, 2'b00};
    wdata_sh  = op_wdata >> nib_off(data_idx + 3'd1);
    case (state)
      CMD:     shift_nib = {3'b000, cmd_sh[0]};
      ADDR:    shift_nib = addr_sh[3:0];
      DATA:    shift_nib = op_we ? wdata_sh[3:0] : 4'h0;
      default: shift_nib = 4'h0;
    endcase
  end

  // Main transaction FSM: outputs change on SCK falls, read data captured on SCK rises
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      gap          <= '0;
      op_we        <= 1'b0;
      op_sel_ok    <= 1'b0;
      op_cmd       <= '0;
      op_addr      <= '0;
      op_size      <= '0;
      op_wdata     <= '0;
      rd_buf       <= '0;
      ack_o        <= 1'b0;
      busy_o       <= 1'b0;
      rdata_o      <= '0;
      mem_cs_on    <= '1;
      mem_sd_o     <= 4'h0;
      mem_sd_oen_o <= OEN_IDLE;
    end else begin
      ack_o <= 1'b0;
      if (gap != '0) gap <= gap - 1'b1;
      case (state)
        IDLE: begin
          if (ack_o) begin
            busy_o <= 1'b0;
          end else if (req_i && !busy_o && gap == '0) begin
            state        <= CMD;
            busy_o       <= 1'b1;
            cnt          <= CNT_W'(7);
            op_we        <= we_i;
            op_sel_ok    <= ~&cs_mask;
            op_cmd       <= we_i ? WR_CMD : RD_CMD;
            op_addr      <= addr_i;
            op_size      <= size_i;
            op_wdata     <= wdata_i;
            rd_buf       <= '0;
            mem_cs_on    <= cs_mask;
            mem_sd_o     <= {3'b000, we_i ? WR_CMD[7] : RD_CMD[7]};
            mem_sd_oen_o <= OEN_CMD;
          end
        end
        DONE: begin
          if (cnt == '0) begin
            state   <= IDLE;
            ack_o   <= 1'b1;
            if (!op_we) rdata_o <= op_sel_ok ? rd_buf : 32'h0;
          end else begin
            cnt <= cnt_m1;
          end
        end
        default: begin
          if (sck_rise && state == DATA && !op_we)
            rd_buf <= rd_buf | ({28'h0, mem_sd_i} << data_off);
          if (sck_fall) begin
            if (cnt != '0) begin
              cnt      <= cnt_m1;
              mem_sd_o <= shift_nib;
            end else begin
              case (state)
                CMD: begin
                  state        <= ADDR;
                  cnt          <= CNT_W'(ANIB - 1);
                  mem_sd_o     <= op_addr[ADDR_W-1 -: 4];
                  mem_sd_oen_o <= OEN_ADDR;
                end
                ADDR: begin
                  if (!op_we && DUMMY_CYC > 0) begin
                    state        <= DUMMY;
                    cnt          <= CNT_W'(DUMMY_CYC - 1);
                    mem_sd_o     <= 4'h0;
                    mem_sd_oen_o <= OEN_DUMMY;
                  end else begin
                    state        <= DATA;
                    cnt          <= CNT_W'(last_idx);
                    mem_sd_o     <= op_we ? op_wdata[7:4] : 4'h0;
                    mem_sd_oen_o <= op_we ? OEN_WDATA : OEN_RDATA;
                  end
                end
                DUMMY: begin
                  state        <= DATA;
                  cnt          <= CNT_W'(last_idx);
                  mem_sd_o     <= op_we ? op_wdata[7:4] : 4'h0;
                  mem_sd_oen_o <= op_we ? OEN_WDATA : OEN_RDATA;
                end
                default: begin
                  state        <= DONE;
                  cnt          <= CNT_W'(1);
                  gap          <= GAP_W'(2 * CLK_DIV - 1);
                  mem_cs_on    <= '1;
                  mem_sd_o     <= 4'h0;
                  mem_sd_oen_o <= OEN_IDLE;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_mem_ctrl.sv
// tb/tb_qspi_mem_ctrl.sv - directed self-checking bench for qspi_mem_ctrl
module tb_qspi_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = 3'b000;
  logic        we = 1'b0;
  logic [1:0]  cs_sel = 2'b00;
  logic [23:0] addr = '0;
  logic [1:0]  size = '0;
  logic [31:0] wdata = '0;

  logic [2:0]  ack, busy, sck;
  logic [31:0] rd0, rd1, rd2;
  logic [1:0]  cs0;
  logic [3:0]  cs1;
  logic [2:0]  cs2;
  logic [3:0]  sdo0, sdo1, sdo2, oen0, oen1, oen2;
  logic [3:0]  sdi0;
  logic [3:0]  sdi1 = 4'h0;
  logic [3:0]  sdi2 = 4'hF;

  int errors = 0;
  int checks = 0;

  logic [31:0] dev_word = 32'hDEADBEEF;
  int r0 = 0, f0 = 0, r1 = 0;
  int base0 = 0, fb0 = 0, base1 = 0;
  logic [3:0] log0_sd [1024];
  logic [3:0] log0_oen[1024];
  logic [3:0] log1_sd [1024];
  logic [3:0] log1_oen[1024];

  always #5 clk = ~clk;

  qspi_mem_ctrl u0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we), .cs_sel_i(cs_sel[0:0]),
    .addr_i(addr), .size_i(size), .wdata_i(wdata), .ack_o(ack[0]), .rdata_o(rd0),
    .busy_o(busy[0]), .mem_cs_on(cs0), .mem_sck_o(sck[0]), .mem_sd_i(sdi0),
    .mem_sd_o(sdo0), .mem_sd_oen_o(oen0)
  );

  qspi_mem_ctrl #(.NUM_CS(4), .CLK_DIV(2)) u1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we), .cs_sel_i(cs_sel),
    .addr_i(addr), .size_i(size), .wdata_i(wdata), .ack_o(ack[1]), .rdata_o(rd1),
    .busy_o(busy[1]), .mem_cs_on(cs1), .mem_sck_o(sck[1]), .mem_sd_i(sdi1),
    .mem_sd_o(sdo1), .mem_sd_oen_o(oen1)
  );

  qspi_mem_ctrl #(.NUM_CS(3)) u2 (
    .clk_i(clk), .rst_i(rst), .req_i(req[2]), .we_i(we), .cs_sel_i(cs_sel),
    .addr_i(addr), .size_i(size), .wdata_i(wdata), .ack_o(ack[2]), .rdata_o(rd2),
    .busy_o(busy[2]), .mem_cs_on(cs2), .mem_sck_o(sck[2]), .mem_sd_i(sdi2),
    .mem_sd_o(sdo2), .mem_sd_oen_o(oen2)
  );

  always @(posedge sck[0]) begin
    log0_sd[r0 % 1024]  = sdo0;
    log0_oen[r0 % 1024] = oen0;
    r0++;
  end

  always @(negedge sck[0]) f0++;

  always @(posedge sck[1]) begin
    log1_sd[r1 % 1024]  = sdo1;
    log1_oen[r1 % 1024] = oen1;
    r1++;
  end

  // Device model: after 8 cmd + 6 addr + 4 dummy cycles it returns dev_word, byte 0 first, high nibble first
  always_comb begin
    int d;
    logic [2:0] di;
    d    = f0 - fb0 - 18;
    di   = d[2:0];
    sdi0 = (d >= 0 && d < 8) ? dev_word[{di[2:1], ~di[0], 2'b00} +: 4] : 4'h0;
  end

  function automatic logic [3:0] csv(input int u);
    if (u == 0) return {2'b11, cs0};
    if (u == 1) return cs1;
    return {1'b1, cs2};
  endfunction

  function automatic logic [31:0] rdv(input int u);
    if (u == 0) return rd0;
    if (u == 1) return rd1;
    return rd2;
  endfunction

  task automatic issue(input int u, output int lat, output logic busy_seen,
                       output logic [3:0] cs_snap, output logic [3:0] cs_and,
                       output logic [31:0] rd, output logic ack_next, output logic busy_next);
    @(negedge clk);
    base0 = r0; fb0 = f0; base1 = r1;
    req[u] = 1'b1;
    @(posedge clk); #1;
    req[u] = 1'b0;
    busy_seen = busy[u];
    cs_and = csv(u);
    cs_snap = 4'hF;
    rd = 32'hX;
    lat = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      cs_and &= csv(u);
      if (i == 10) cs_snap = csv(u);
      if (ack[u]) begin
        lat = i;
        rd = rdv(u);
        break;
      end
    end
    @(posedge clk); #1;
    ack_next = ack[u];
    busy_next = busy[u];
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    checks++; if (cs0 !== 2'b11) begin errors++; $display("FAIL reset_cs0 got %b want 11", cs0); end
    checks++; if (cs1 !== 4'hF) begin errors++; $display("FAIL reset_cs1 got %b want 1111", cs1); end
    checks++; if (sck !== 3'b000) begin errors++; $display("FAIL reset_sck got %b want 000", sck); end
    checks++; if (sdo0 !== 4'h0 || oen0 !== 4'h0) begin errors++; $display("FAIL reset_sd got sd=%h oen=%h want 0/0", sdo0, oen0); end
    checks++; if (ack !== 3'b000 || busy !== 3'b000) begin errors++; $display("FAIL reset_ack_busy got ack=%b busy=%b want 000/000", ack, busy); end
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rd0); end
    // reset and request together: reset wins
    @(negedge clk);
    req[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req[0] = 1'b0;
    checks++; if (busy[0] !== 1'b0 || cs0 !== 2'b11) begin errors++; $display("FAIL rst_req_drop got busy=%b cs=%b want 0/11", busy[0], cs0); end
    @(posedge clk); #1;
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_req_late got busy=%b want 0", busy[0]); end
  endtask

  task automatic test_read;
    int lat; logic bs, an, bn; logic [3:0] snap, cand; logic [31:0] rd;
    logic [7:0] op; logic [23:0] ad;
    we = 1'b0; cs_sel = 2'd0; addr = 24'h001234; size = 2'd3;
    issue(0, lat, bs, snap, cand, rd, an, bn);
    for (int k = 0; k < 8; k++) op[7-k] = log0_sd[(base0 + k) % 1024][0];
    for (int k = 0; k < 6; k++) ad[23-4*k -: 4] = log0_sd[(base0 + 8 + k) % 1024];
    checks++; if (lat !== 54) begin errors++; $display("FAIL read_latency got %0d want 54", lat); end
    checks++; if (bs !== 1'b1) begin errors++; $display("FAIL read_busy got %b want 1", bs); end
    checks++; if (snap[1:0] !== 2'b10) begin errors++; $display("FAIL read_cs got %b want 10", snap[1:0]); end
    checks++; if (op !== 8'hEB) begin errors++; $display("FAIL read_opcode got %h want eb", op); end
    checks++; if (ad !== 24'h001234) begin errors++; $display("FAIL read_addr got %h want 001234", ad); end
    checks++; if (log0_oen[base0 % 1024] !== 4'b0001 || log0_oen[(base0 + 8) % 1024] !== 4'b1111)
      begin errors++; $display("FAIL read_oen_cmd_addr got %b/%b want 0001/1111", log0_oen[base0 % 1024], log0_oen[(base0 + 8) % 1024]); end
    checks++; if (log0_oen[(base0 + 14) % 1024] !== 4'b0000 || log0_oen[(base0 + 18) % 1024] !== 4'b0000)
      begin errors++; $display("FAIL read_oen_dummy_data got %b/%b want 0000/0000", log0_oen[(base0 + 14) % 1024], log0_oen[(base0 + 18) % 1024]); end
    checks++; if (r0 - base0 !== 26) begin errors++; $display("FAIL read_sck_cycles got %0d want 26", r0 - base0); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata got %h want deadbeef", rd); end
    checks++; if (an !== 1'b0 || bn !== 1'b0) begin errors++; $display("FAIL read_ack_once got ack=%b busy=%b want 0/0", an, bn); end
    checks++; if (rd0 !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata_hold got %h want deadbeef", rd0); end
  endtask

  task automatic test_size1;
    int lat; logic bs, an, bn; logic [3:0] snap, cand; logic [31:0] rd;
    we = 1'b0; cs_sel = 2'd0; addr = 24'h000010; size = 2'd1;
    issue(0, lat, bs, snap, cand, rd, an, bn);
    checks++; if (lat !== 46) begin errors++; $display("FAIL size1_latency got %0d want 46", lat); end
    checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL size1_rdata got %h want 0000beef", rd); end
    checks++; if (r0 - base0 !== 22) begin errors++; $display("FAIL size1_sck_cycles got %0d want 22", r0 - base0); end
  endtask

  task automatic test_write;
    int lat; logic bs, an, bn; logic [3:0] snap, cand; logic [31:0] rd;
    logic [7:0] op;
    we = 1'b1; cs_sel = 2'd1; addr = 24'hABCDEF; size = 2'd0; wdata = 32'h000000A5;
    issue(1, lat, bs, snap, cand, rd, an, bn);
    for (int k = 0; k < 8; k++) op[7-k] = log1_sd[(base1 + k) % 1024][0];
    checks++; if (lat !== 66) begin errors++; $display("FAIL write_latency got %0d want 66", lat); end
    checks++; if (snap !== 4'b1101) begin errors++; $display("FAIL write_cs got %b want 1101", snap); end
    checks++; if (op !== 8'h38) begin errors++; $display("FAIL write_opcode got %h want 38", op); end
    checks++; if (log1_sd[(base1 + 14) % 1024] !== 4'hA || log1_sd[(base1 + 15) % 1024] !== 4'h5)
      begin errors++; $display("FAIL write_data got %h,%h want a,5", log1_sd[(base1 + 14) % 1024], log1_sd[(base1 + 15) % 1024]); end
    checks++; if (log1_oen[(base1 + 14) % 1024] !== 4'b1111 || log1_oen[(base1 + 15) % 1024] !== 4'b1111)
      begin errors++; $display("FAIL write_oen got %b,%b want 1111,1111", log1_oen[(base1 + 14) % 1024], log1_oen[(base1 + 15) % 1024]); end
    checks++; if (r1 - base1 !== 16) begin errors++; $display("FAIL write_sck_cycles got %0d want 16", r1 - base1); end
  endtask

  task automatic test_cs3;
    int lat; logic bs, an, bn; logic [3:0] snap, cand; logic [31:0] rd;
    we = 1'b1; cs_sel = 2'd3; addr = 24'h000000; size = 2'd0; wdata = 32'h0000003C;
    issue(1, lat, bs, snap, cand, rd, an, bn);
    checks++; if (snap !== 4'b0111) begin errors++; $display("FAIL cs3_select got %b want 0111", snap); end
    checks++; if (lat !== 66) begin errors++; $display("FAIL cs3_latency got %0d want 66", lat); end
  endtask

  task automatic test_out_of_range;
    int lat; logic bs, an, bn; logic [3:0] snap, cand; logic [31:0] rd;
    we = 1'b0; cs_sel = 2'd3; addr = 24'h001234; size = 2'd3;
    issue(2, lat, bs, snap, cand, rd, an, bn);
    checks++; if (cand !== 4'b1111) begin errors++; $display("FAIL oor_no_cs got %b want 1111", cand); end
    checks++; if (lat !== 54) begin errors++; $display("FAIL oor_ack got latency %0d want 54", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rdata got %h want 0", rd); end
  endtask

  task automatic test_back_to_back;
    int acks = 0, lows = 0, run = 0, mingap = 9999;
    logic prev = 1'b1, c;
    we = 1'b1; cs_sel = 2'd0; addr = 24'h000100; size = 2'd0; wdata = 32'h0000005A;
    @(negedge clk);
    req[1] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (ack[1]) acks++;
      c = cs1[0];
      if (c) run++;
      else begin
        if (prev && lows > 0 && run < mingap) mingap = run;
        if (prev) lows++;
        run = 0;
      end
      prev = c;
      if (lows == 2) req[1] = 1'b0;
    end
    req[1] = 1'b0;
    checks++; if (acks !== 2) begin errors++; $display("FAIL b2b_acks got %0d want 2", acks); end
    checks++; if (lows !== 2) begin errors++; $display("FAIL b2b_transactions got %0d want 2", lows); end
    checks++; if (mingap < 4) begin errors++; $display("FAIL b2b_cs_gap got %0d want >=4", mingap); end
  endtask

  task automatic test_reset_mid;
    int acks = 0;
    logic reached = 1'b0;
    we = 1'b0; cs_sel = 2'd0; addr = 24'h001234; size = 2'd3;
    @(negedge clk);
    base0 = r0; fb0 = f0;
    req[0] = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (r0 - base0 >= 10) begin reached = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!reached) begin errors++; $display("FAIL rstmid_reach_addr got timeout want addr phase"); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (cs0 !== 2'b11 || sck[0] !== 1'b0 || oen0 !== 4'h0)
      begin errors++; $display("FAIL rstmid_outputs got cs=%b sck=%b oen=%b want 11/0/0000", cs0, sck[0], oen0); end
    checks++; if (busy[0] !== 1'b0 || sdo0 !== 4'h0) begin errors++; $display("FAIL rstmid_busy got busy=%b sd=%h want 0/0", busy[0], sdo0); end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ack[0]) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL rstmid_no_ack got %0d want 0", acks); end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    test_reset;
    test_read;
    test_size1;
    test_write;
    test_cs3;
    test_out_of_range;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qspi_mem_ctrl.md
# qspi_mem_ctrl

Parametrised quad-SPI memory controller driving up to NUM_CS external QSPI devices (ROM, RAM, further PSRAM) over one shared SCK/SD[3:0] bus. It generalises the fixed two-device ROM/RAM port to N chip selects with:

- configurable address width,
- configurable dummy cycles,
- an SCK divider,
- 1–4 byte transfers.

It sits between the core's memory request port and the chip's bidirectional IO pins. The pad-level oen-to-oe mapping stays in the top wrapper.

## Interface
Parameters:
- NUM_CS, 2, number of chip selects (≥1).
- ADDR_W, 24, address bits sent; multiple of 4, ≤32.
- DUMMY_CYC, 4, SCK cycles between address and read data.
- CLK_DIV, 1, SCK half-period in clk_i cycles (≥1).
- RD_CMD, 8'hEB, read opcode.
- WR_CMD, 8'h38, write opcode.

Ports (clock and reset first). One clock; reset is synchronous and active-high.
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  1  transaction request.
- we_i  in  1  1 = write, 0 = read.
- cs_sel_i  in  $clog2(NUM_CS) (min 1)  target device index.
- addr_i  in  ADDR_W  byte address.
- size_i  in  2  byte count minus 1.
- wdata_i  in  32  write data, byte 0 in [7:0].
- ack_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  read data; unread bytes are 0.
- busy_o  out  1  transaction in progress.
- mem_cs_on  out  NUM_CS  active-low chip selects.
- mem_sck_o  out  1  serial clock, idles low.
- mem_sd_i  in  4  serial data in.
- mem_sd_o  out  4  serial data out.
- mem_sd_oen_o  out  4  per-line output enable, 1 = drive.

## Operation
- Reset values: mem_cs_on all 1; mem_sck_o, mem_sd_o, mem_sd_oen_o, ack_o, busy_o = 0; rdata_o = 0.
- FSM states: IDLE → CMD → ADDR → (DUMMY if read) → DATA → DONE → IDLE.
- Request capture:
  - In IDLE, req_i=1 captures all request inputs.
  - busy_o rises on the next cycle.
  - req_i is ignored while busy_o=1.
- Chip select: the selected mem_cs_on bit goes low on entry to CMD and returns high on entry to DONE.
- CMD phase: 8 SCK cycles. Opcode is sent MSB-first on sd[0] only; oen=4'b0001.
- ADDR phase: ADDR_W/4 SCK cycles. Address is sent MSB nibble first on sd[3:0]; oen=4'b1111.
- DUMMY phase (reads only): DUMMY_CYC SCK cycles; oen=4'b0000.
- DATA phase: 2·(size_i+1) SCK cycles.
  - Bytes go in ascending order (byte 0 first); within each byte, high nibble first.
  - Write: oen=4'b1111.
  - Read: oen=4'b0000; nibbles are shifted into rdata_o.
- Out-of-range select: if cs_sel_i ≥ NUM_CS, the full sequence runs with no CS asserted. ack_o is still issued; rdata_o=0.
- DONE: ack_o=1 for exactly one cycle; busy_o=0 from the following cycle.
- CS gap: mem_cs_on stays high at least 2·CLK_DIV clk cycles between transactions. IDLE does not accept a new request until this gap has elapsed.

## Timing
- SCK period is 2·CLK_DIV clk cycles.
- Output data changes on the clk edge that drives SCK low; input data is sampled on the clk edge that drives SCK high.
- Let N = 8 + ADDR_W/4 + (we ? 0 : DUMMY_CYC) + 2·(size_i+1).
- Latency: ack_o is asserted exactly 2·CLK_DIV·N + 2 cycles after the accepting edge.
- rdata_o is valid while ack_o=1 and holds its value until the next read completes.
- Reset mid-transaction: on the cycle after rst_i=1, all outputs take their reset values, SCK stops low, and no ack_o is issued.
- Simultaneous rst_i and req_i: reset wins; the request is dropped.

## Structure
- Package qspi_pkg holds:
  - the state enum (IDLE, CMD, ADDR, DUMMY, DATA, DONE);
  - default opcode constants;
  - the oen pattern constants per phase.
- Sub-module qspi_sck_gen is the CLK_DIV counter. It outputs sck, plus one-cycle rise and fall strobes that drive the main FSM's sample and shift points.
- The main FSM has one phase counter, sized for the largest phase, that is reloaded at each phase entry.

## Test plan
- Read at defaults: addr 0x001234, size 3, cs_sel 0, device model returns 0xDEADBEEF (byte 0 = 0xEF).
  - Opcode EB appears on sd[0].
  - Address nibbles 0,0,1,2,3,4 follow.
  - After 4 dummy cycles, rdata_o=0xDEADBEEF.
  - ack_o arrives 54 cycles after acceptance.
- Write: cs_sel 1, size 0, wdata 0xA5, CLK_DIV=2.
  - Only mem_cs_on[1] goes low; opcode 38 is sent.
  - Data nibbles A then 5; oen=1111 during data.
  - ack_o at 2·2·16+2 = 66 cycles.
- Back-to-back requests with req_i held high: CS stays high ≥ 2·CLK_DIV cycles between transactions, and exactly one ack_o per transaction.
- rst_i asserted during ADDR: next cycle, mem_cs_on all 1, sck 0, oen 0; no ack_o follows.
- NUM_CS=4, cs_sel_i=3: mem_cs_on=4'b0111 during the transaction.
  - Same run with NUM_CS=3: no CS asserted, ack_o still issued, rdata_o=0.
- Size 1 read: only rdata_o[15:0] is populated and [31:16]=0; the DATA phase lasts 4 SCK cycles.
